// File: rtl/ws_pkg.sv
// Shared types and defaults for the weight-stationary tile controller.
// Included first so the controller and its window decoder agree on widths.
package ws_pkg;

  localparam int DEF_ROWS     = 3;
  localparam int DEF_COLS     = 3;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_PSUM_LAT = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DONE
  } state_t;

  typedef logic [DEF_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/ws_tile_controller_window.sv
// Skewed window decode: active while offset <= t < offset+len,
// index is the position inside that window.
module ws_skew_window #(
  parameter int CNT_W = 16
) (
  input  logic [CNT_W:0]   t,
  input  logic [CNT_W:0]   offset,
  input  logic [CNT_W-1:0] len,
  output logic             active,
  output logic [CNT_W-1:0] index
);

  logic [CNT_W:0] diff;

  assign diff   = t - offset;
  assign active = (t >= offset) && (diff < {1'b0, len});
  assign index  = active ? diff[CNT_W-1:0] : '0;

endmodule

// File: rtl/ws_tile_controller.sv
// Weight-stationary tile sequencer: loads a weight tile, then streams
// skewed iacts and collects skewed psums, tile after tile.
module ws_tile_controller
  import ws_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int PSUM_LAT = DEF_PSUM_LAT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          go,
  input  logic [CNT_W-1:0]              cfg_num_tiles,
  input  logic [CNT_W-1:0]              cfg_iact_len,
  input  logic                          cfg_accum,
  output logic                          busy,
  output logic                          done,
  output logic                          load_weight,
  output logic [ADDR_W-1:0]             weight_addr,
  output logic [COLS-1:0]               load_iact,
  output logic [COLS-1:0][ADDR_W-1:0]   iact_addr,
  output logic [ROWS-1:0]               psum_valid,
  output logic [ROWS-1:0][ADDR_W-1:0]   psum_addr,
  output logic [ROWS-1:0]               psum_accum
);

  localparam int STEP_W = CNT_W + 1;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]    tile_q, tile_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic                acc_q, acc_d;
  logic [STEP_W-1:0]   t_last;

  assign t_last = {1'b0, len_q}
                + STEP_W'(COLS + ROWS + PSUM_LAT - 2);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tile_d  = tile_q;
    num_d   = num_q;
    len_d   = len_q;
    acc_d   = acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          num_d  = cfg_num_tiles;
          len_d  = cfg_iact_len;
          acc_d  = cfg_accum;
          tile_d = '0;
          step_d = '0;
          if (cfg_num_tiles != '0 && cfg_iact_len != '0)
            state_d = S_LOAD_W;
          else
            state_d = S_DONE;
        end
      end
      S_LOAD_W: begin
        if (step_q == STEP_W'(ROWS - 1)) begin
          step_d  = '0;
          state_d = S_STREAM;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_STREAM: begin
        if (step_q == t_last) begin
          step_d = '0;
          if (tile_q != num_q - CNT_W'(1)) begin
            tile_d  = tile_q + 1'b1;
            state_d = S_LOAD_W;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Windows decode the next step so the outputs can be registered.
  logic [COLS-1:0]            col_act;
  logic [COLS-1:0][CNT_W-1:0] col_idx;
  logic [ROWS-1:0]            row_act;
  logic [ROWS-1:0][CNT_W-1:0] row_idx;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    ws_skew_window #(.CNT_W(CNT_W)) u_win (
      .t      (step_d),
      .offset (STEP_W'(c)),
      .len    (len_d),
      .active (col_act[c]),
      .index  (col_idx[c])
    );
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    ws_skew_window #(.CNT_W(CNT_W)) u_win (
      .t      (step_d),
      .offset (STEP_W'(COLS + r + PSUM_LAT)),
      .len    (len_d),
      .active (row_act[r]),
      .index  (row_idx[r])
    );
  end

  logic                        busy_d, busy_q;
  logic                        done_d, done_q;
  logic                        lw_d, lw_q;
  logic [ADDR_W-1:0]           wa_d, wa_q;
  logic [COLS-1:0]             li_d, li_q;
  logic [COLS-1:0][ADDR_W-1:0] ia_d, ia_q;
  logic [ROWS-1:0]             pv_d, pv_q;
  logic [ROWS-1:0][ADDR_W-1:0] pa_d, pa_q;
  logic [ROWS-1:0]             pacc_d, pacc_q;
  logic                        stream_d;
  logic [ADDR_W-1:0]           base_d;

  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    lw_d     = (state_d == S_LOAD_W);
    stream_d = (state_d == S_STREAM);
    wa_d     = '0;
    li_d     = '0;
    ia_d     = '0;
    pv_d     = '0;
    pa_d     = '0;
    pacc_d   = '0;
    base_d   = acc_d ? '0 : ADDR_W'(tile_d) * ADDR_W'(len_d);
    if (lw_d)
      wa_d = ADDR_W'(tile_d) * ADDR_W'(ROWS) + ADDR_W'(step_d);
    for (int c = 0; c < COLS; c++) begin
      li_d[c] = stream_d & col_act[c];
      if (li_d[c])
        ia_d[c] = ADDR_W'(col_idx[c]);
    end
    for (int r = 0; r < ROWS; r++) begin
      pv_d[r] = stream_d & row_act[r];
      if (pv_d[r]) begin
        pa_d[r]   = base_d + ADDR_W'(row_idx[r]);
        pacc_d[r] = acc_d & (tile_d != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      tile_q  <= '0;
      num_q   <= '0;
      len_q   <= '0;
      acc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lw_q    <= 1'b0;
      wa_q    <= '0;
      li_q    <= '0;
      ia_q    <= '0;
      pv_q    <= '0;
      pa_q    <= '0;
      pacc_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      tile_q  <= tile_d;
      num_q   <= num_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lw_q    <= lw_d;
      wa_q    <= wa_d;
      li_q    <= li_d;
      ia_q    <= ia_d;
      pv_q    <= pv_d;
      pa_q    <= pa_d;
      pacc_q  <= pacc_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign load_weight = lw_q;
  assign weight_addr = wa_q;
  assign load_iact   = li_q;
  assign iact_addr   = ia_q;
  assign psum_valid  = pv_q;
  assign psum_addr   = pa_q;
  assign psum_accum  = pacc_q;

endmodule

// File: tb/tb_ws_tile_controller.sv
// Directed bench for ws_tile_controller (3x3 array, PSUM_LAT=1):
// cycle-by-cycle expected traces built from the run timeline.
module tb_ws_tile_controller;
  import ws_pkg::*;

  localparam int ROWS = 3;
  localparam int COLS = 3;
  localparam int AW   = 32;
  localparam int CW   = 16;
  localparam int LAT  = 1;

  logic                    clk;
  logic                    rst;
  logic                    go;
  logic [CW-1:0]           cfg_num_tiles;
  logic [CW-1:0]           cfg_iact_len;
  logic                    cfg_accum;
  logic                    busy;
  logic                    done;
  logic                    load_weight;
  logic [AW-1:0]           weight_addr;
  logic [COLS-1:0]         load_iact;
  logic [COLS-1:0][AW-1:0] iact_addr;
  logic [ROWS-1:0]         psum_valid;
  logic [ROWS-1:0][AW-1:0] psum_addr;
  logic [ROWS-1:0]         psum_accum;

  int n_tests;
  int n_fail;

  ws_tile_controller #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .ADDR_W   (AW),
    .CNT_W    (CW),
    .PSUM_LAT (LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .go            (go),
    .cfg_num_tiles (cfg_num_tiles),
    .cfg_iact_len  (cfg_iact_len),
    .cfg_accum     (cfg_accum),
    .busy          (busy),
    .done          (done),
    .load_weight   (load_weight),
    .weight_addr   (weight_addr),
    .load_iact     (load_iact),
    .iact_addr     (iact_addr),
    .psum_valid    (psum_valid),
    .psum_addr     (psum_addr),
    .psum_accum    (psum_accum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " lw"}, 64'(load_weight), 64'd0);
    chk({tag, " wa"}, 64'(weight_addr), 64'd0);
    chk({tag, " li"}, 64'(load_iact), 64'd0);
    chk({tag, " pv"}, 64'(psum_valid), 64'd0);
    chk({tag, " pacc"}, 64'(psum_accum), 64'd0);
    for (int i = 0; i < COLS; i++)
      chk($sformatf("%s ia%0d", tag, i), 64'(iact_addr[i]), 64'd0);
    for (int i = 0; i < ROWS; i++)
      chk($sformatf("%s pa%0d", tag, i), 64'(psum_addr[i]), 64'd0);
  endtask

  // One run: go at cycle 0, optional stray go at go_at,
  // optional reset at rst_at (outputs cleared the cycle after).
  task automatic run(input int nt, input int len, input bit acc,
                     input int go_at, input int rst_at);
    int      neff, per, last, k, tl, ph, t, d;
    bit      e_busy, e_done, e_lw;
    addr_t   e_wa;
    logic [COLS-1:0] e_li;
    logic [ROWS-1:0] e_pv, e_pacc;
    addr_t   e_ia[COLS];
    addr_t   e_pa[ROWS];
    string   s;
    neff = (nt == 0 || len == 0) ? 0 : nt;
    per  = ROWS + len + COLS + ROWS - 1 + LAT;
    last = neff * per;
    cfg_num_tiles = CW'(nt);
    cfg_iact_len  = CW'(len);
    cfg_accum     = acc;
    go            = 1'b1;
    tick();
    go            = 1'b0;
    cfg_num_tiles = 16'd7;
    cfg_iact_len  = 16'd9;
    cfg_accum     = ~acc;
    for (int c = 1; c <= last + 2; c++) begin
      e_busy = 0; e_done = 0; e_lw = 0; e_wa = '0;
      e_li = '0; e_pv = '0; e_pacc = '0;
      for (int i = 0; i < COLS; i++) e_ia[i] = '0;
      for (int i = 0; i < ROWS; i++) e_pa[i] = '0;
      k = c - 1;
      if (rst_at != 0 && c > rst_at) begin
        chk_zero($sformatf("c%0d rst", c));
        rst = 1'b0;
        repeat (4) begin
          tick();
          chk("post-rst done", 64'(done), 64'd0);
          chk("post-rst busy", 64'(busy), 64'd0);
        end
        return;
      end
      if (k < last) begin
        e_busy = 1;
        tl = k / per;
        ph = k % per;
        if (ph < ROWS) begin
          e_lw = 1;
          e_wa = addr_t'(tl * ROWS + ph);
        end else begin
          t = ph - ROWS;
          for (int i = 0; i < COLS; i++)
            if (t >= i && t < i + len) begin
              e_li[i] = 1'b1;
              e_ia[i] = addr_t'(t - i);
            end
          for (int i = 0; i < ROWS; i++) begin
            d = COLS + i + LAT;
            if (t >= d && t < d + len) begin
              e_pv[i]   = 1'b1;
              e_pa[i]   = addr_t'(acc ? t - d : tl * len + t - d);
              e_pacc[i] = acc && tl > 0;
            end
          end
        end
      end else if (k == last) begin
        e_busy = 1;
        e_done = 1;
      end
      s = $sformatf("n%0d L%0d a%0d c%0d", nt, len, acc, c);
      chk({s, " busy"}, 64'(busy), 64'(e_busy));
      chk({s, " done"}, 64'(done), 64'(e_done));
      chk({s, " lw"}, 64'(load_weight), 64'(e_lw));
      chk({s, " wa"}, 64'(weight_addr), 64'(e_wa));
      chk({s, " li"}, 64'(load_iact), 64'(e_li));
      chk({s, " pv"}, 64'(psum_valid), 64'(e_pv));
      chk({s, " pacc"}, 64'(psum_accum), 64'(e_pacc));
      for (int i = 0; i < COLS; i++)
        chk($sformatf("%s ia%0d", s, i), 64'(iact_addr[i]), 64'(e_ia[i]));
      for (int i = 0; i < ROWS; i++)
        chk($sformatf("%s pa%0d", s, i), 64'(psum_addr[i]), 64'(e_pa[i]));
      go  = (c == go_at);
      rst = (c == rst_at);
      tick();
    end
    go = 1'b0;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    go            = 1'b0;
    cfg_num_tiles = '0;
    cfg_iact_len  = '0;
    cfg_accum     = 1'b0;
    repeat (2) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();
    chk_zero("idle");
    run(1, 4, 1'b0, 0, 0);
    run(2, 2, 1'b0, 0, 0);
    run(2, 2, 1'b1, 0, 0);
    run(1, 0, 1'b0, 0, 0);
    run(0, 3, 1'b1, 0, 0);
    run(2, 2, 1'b0, 6, 0);
    run(1, 4, 1'b0, 0, 7);
    run(1, 4, 1'b1, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ws_tile_controller.md
WS_TILE_CONTROLLER -- requirements
Module: ws_tile_controller

Interface
REQ-001 SHALL have parameter ROWS, default 3, PE array rows (weight/psum channels).
REQ-002 SHALL have parameter COLS, default 3, PE array columns (iact channels).
REQ-003 SHALL have parameter ADDR_W, default 32, width of every address output.
REQ-004 SHALL have parameter CNT_W, default 16, width of configuration counts.
REQ-005 SHALL have parameter PSUM_LAT, default 1, PE pipeline cycles from last column to psum output.
REQ-006 clk  input  1  sole clock; all logic is rising-edge.
REQ-007 rst  input  1  reset; synchronous and active-high.
REQ-008 go  input  1  start pulse; sampled only in IDLE.
REQ-009 cfg_num_tiles  input  CNT_W  number of weight tiles to process.
REQ-010 cfg_iact_len  input  CNT_W  iact vectors (L) streamed per tile.
REQ-011 cfg_accum  input  1  1 = all tiles accumulate into one psum region.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 load_weight  output  1  PE array weight shift enable.
REQ-015 weight_addr  output  ADDR_W  weight memory read address.
REQ-016 load_iact  output  COLS  per-column iact valid.
REQ-017 iact_addr  output  COLS x ADDR_W  per-column iact read address.
REQ-018 psum_valid  output  ROWS  per-row psum write enable.
REQ-019 psum_addr  output  ROWS x ADDR_W  per-row psum write address.
REQ-020 psum_accum  output  ROWS  per-row read-modify-write request, qualified by psum_valid.

Function
REQ-021 SHALL implement states IDLE, LOAD_W, STREAM, DONE.
REQ-022 IDLE: go=1 latches all cfg_* inputs; nonzero tiles and L -> LOAD_W, else -> DONE.
REQ-023 LOAD_W: lasts exactly ROWS cycles, i = 0..ROWS-1; load_weight=1 and weight_addr = tile*ROWS + i; then -> STREAM.
REQ-024 STREAM: lasts T = L + COLS + ROWS - 1 + PSUM_LAT cycles, t = 0..T-1.
REQ-025 In STREAM, load_iact[c]=1 iff c <= t <= c+L-1, with iact_addr[c] = t-c.
REQ-026 In STREAM, psum_valid[r]=1 iff D <= t <= D+L-1, D = COLS+r+PSUM_LAT, with k = t-D.
REQ-027 psum_addr[r] = k when cfg_accum=1, else tile*L + k.
REQ-028 psum_accum[r] = cfg_accum AND tile>0, qualified by psum_valid[r].
REQ-029 End of STREAM: tile < num_tiles-1 -> tile+1, LOAD_W; otherwise -> DONE.
REQ-030 DONE: done=1 for exactly one cycle, then -> IDLE.
REQ-031 go while busy SHALL be ignored; cfg changes after go SHALL have no effect until the next run.
REQ-032 Outputs not qualified by their enable SHALL be driven 0.
REQ-033 All outputs SHALL be registered (no combinational path from inputs to outputs).
REQ-034 Address arithmetic SHALL be unsigned, zero-extended to ADDR_W, wrapping modulo 2^ADDR_W.

Reset
REQ-035 rst=1 SHALL force IDLE and clear tile/step counters and latched config on the next clock edge, including mid-LOAD_W/STREAM.
REQ-036 All outputs SHALL be 0 in the cycle after reset is sampled; no done pulse SHALL follow an aborted run.

Structure
REQ-037 State enum, default parameter values and address-width typedef SHALL live in shared package ws_pkg.
REQ-038 Per-row/per-column window decode SHALL be a sub-module ws_skew_window (inputs t, offset, L; outputs active, index), instantiated COLS+ROWS times.

Verification (ROWS=COLS=3, PSUM_LAT=1; go sampled at cycle 0)
REQ-039 Reset: hold rst 2 cycles -> all outputs 0, busy=0.
REQ-040 Single tile, L=4: load_weight cycles 1-3 (weight_addr 0,1,2); STREAM cycles 4-13; load_iact[2] t=2..5 (addr 0..3); psum_valid[0] t=4..7 (addr 0..3); psum_valid[2] t=6..9; done at cycle 14 only.
REQ-041 Two tiles, L=2, cfg_accum=0: tile 1 weight_addr 3,4,5; tile 1 psum_addr[r] 2,3; psum_accum stays 0.
REQ-042 Two tiles, L=2, cfg_accum=1: tile 1 psum_addr[r] 0,1 with psum_accum[r]=1; tile 0 psum_accum=0.
REQ-043 cfg_iact_len=0 (or cfg_num_tiles=0): done=1 at cycle 1; no load_weight, load_iact or psum_valid ever asserts.
REQ-044 go pulsed mid-STREAM -> ignored, run unchanged; rst at STREAM t=3 -> outputs 0 next cycle, no done; new go -> clean run from tile 0.
